// File: rtl/nco_phase_gen.sv
// rtl/nco_phase_gen.sv - Wishbone-programmed NCO phase generator with valid/ready phase stream
module nco_phase_gen #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ACC_W     = 32,
  parameter int          PHASE_W   = 12,
  parameter int          DIV_W     = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               phase_valid_o,
  input  logic               phase_ready_i
);

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_FTW    = 6'h01;
  localparam logic [5:0] OFF_POFF   = 6'h02;
  localparam logic [5:0] OFF_DIV    = 6'h03;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_ACC    = 6'h05;

  logic             en;
  logic             ovr;
  logic [ACC_W-1:0] ftw_sh;
  logic [ACC_W-1:0] poff_sh;
  logic [ACC_W-1:0] ftw_act;
  logic [ACC_W-1:0] poff_act;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [31:0]      rdata;
  logic [5:0]       off;
  logic             wb_hit;
  logic             wr;
  logic             clr;
  logic             apply;
  logic             tick;
  logic             drop;
  logic             unused_adr;

  // Byte-lane merge for partially written registers
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};
  assign off     = wbs_adr_i[7:2];
  assign wb_hit  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr      = wb_hit & wbs_we_i;
  assign clr     = wr & (off == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[1];
  assign apply   = wr & (off == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[2];
  assign tick    = en & (cnt == '0);
  assign acc_sum = acc + poff_act;
  // A clear on the same edge discards the tick, so it cannot count as an overrun either
  assign drop    = tick & phase_valid_o & ~phase_ready_i & ~clr;

  // Read mux; unmapped offsets inside the window read as zero
  always_comb begin
    rdata = 32'h0;
    case (off)
      OFF_CTRL:   rdata = {31'h0, en};
      OFF_FTW:    rdata = 32'(ftw_sh);
      OFF_POFF:   rdata = 32'(poff_sh);
      OFF_DIV:    rdata = 32'(div);
      OFF_STATUS: rdata = {30'h0, en, ovr};
      OFF_ACC:    rdata = 32'(acc);
      default:    rdata = 32'h0;
    endcase
  end

  // Bus side: single-cycle ack, register writes, APPLY transfer and sticky overrun flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      en        <= 1'b0;
      ovr       <= 1'b0;
      ftw_sh    <= '0;
      poff_sh   <= '0;
      ftw_act   <= '0;
      poff_act  <= '0;
      div       <= '0;
    end else begin
      wbs_ack_o <= wb_hit;
      wbs_dat_o <= (wb_hit & ~wbs_we_i) ? rdata : 32'h0;
      if (wr) begin
        case (off)
          OFF_CTRL:   if (wbs_sel_i[0]) en <= wbs_dat_i[0];
          OFF_FTW:    ftw_sh  <= ACC_W'(merge(32'(ftw_sh), wbs_dat_i, wbs_sel_i));
          OFF_POFF:   poff_sh <= ACC_W'(merge(32'(poff_sh), wbs_dat_i, wbs_sel_i));
          OFF_DIV:    div     <= DIV_W'(merge(32'(div), wbs_dat_i, wbs_sel_i));
          OFF_STATUS: if (wbs_sel_i[0] && wbs_dat_i[0]) ovr <= 1'b0;
          default:    ;
        endcase
      end
      if (apply) begin
        ftw_act  <= ftw_sh;
        poff_act <= poff_sh;
      end
      // A new overrun wins over a simultaneous W1C so no event is lost
      if (drop) ovr <= 1'b1;
    end
  end

  // Datapath: divider, accumulator and output stage; CLR overrides the tick
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt           <= '0;
      acc           <= '0;
      phase_o       <= '0;
      phase_valid_o <= 1'b0;
    end else if (clr) begin
      cnt           <= '0;
      acc           <= '0;
      phase_valid_o <= 1'b0;
    end else begin
      if (!en)       cnt <= '0;
      else if (tick) cnt <= div;
      else           cnt <= cnt - 1'b1;
      if (tick) begin
        acc <= acc + ftw_act;
        if (!phase_valid_o || phase_ready_i) begin
          phase_o       <= acc_sum[ACC_W-1 -: PHASE_W];
          phase_valid_o <= 1'b1;
        end
      end else if (phase_valid_o && phase_ready_i) begin
        phase_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// tb/tb_nco_phase_gen.sv - scoreboard bench for nco_phase_gen with arithmetic phase model
module tb_nco_phase_gen;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_FTW  = BASE + 32'h04;
  localparam logic [31:0] A_POFF = BASE + 32'h08;
  localparam logic [31:0] A_DIV  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;
  localparam logic [31:0] A_ACC  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat_o;
  logic [11:0] phase;
  logic        valid;
  logic        ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [11:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          first_pop = 1'b1;
  int          pops = 0;
  int          cyc_cnt = 0;
  int          last_pop = 0;
  int          exp_period = 1;

  // reference model of programmed state
  logic [31:0] m_acc = 0, m_ftw_act = 0, m_poff_act = 0, m_ftw_sh = 0, m_poff_sh = 0;
  logic [15:0] m_div = 0;

  nco_phase_gen dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .phase_o(phase), .phase_valid_o(valid), .phase_ready_i(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] phase_of(input logic [31:0] a);
    return a[31:20];
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    if (s[0]) r[7:0]   = n[7:0];
    if (s[1]) r[15:8]  = n[15:8];
    if (s[2]) r[23:16] = n[23:16];
    if (s[3]) r[31:24] = n[31:24];
    return r;
  endfunction

  // Monitor: pops one expectation per accepted phase and checks spacing
  always @(negedge clk) begin
    cyc_cnt++;
    if (mon_en && !rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_phase", {20'h0, phase}, 32'hFFFF_FFFF);
      end else begin
        chk("phase", {20'h0, phase}, {20'h0, exp_q.pop_front()});
      end
      if (!first_pop) chk("period", cyc_cnt - last_pop, exp_period);
      first_pop = 1'b0;
      last_pop = cyc_cnt;
      pops++;
    end
  end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic got);
    @(posedge clk); #2;
    stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
    got = 0; rd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1; rd = rdat_o;
        break;
      end
    end
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] rd; logic got;
    xfer(a, 1'b1, d, s, rd, got);
    chk("wr_ack", {31'h0, got}, 1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic got;
    xfer(a, 1'b0, 32'h0, 4'hF, rd, got);
    chk({name, "_ack"}, {31'h0, got}, 1);
    chk(name, rd, exp);
  endtask

  task automatic apply_model();
    m_ftw_act = m_ftw_sh;
    m_poff_act = m_poff_sh;
  endtask

  // Enable, let n phases through with ready high, stop, then verify ACC
  task automatic run(input int n);
    logic [31:0] kk, a;
    int limit;
    exp_q.delete();
    for (int k = 0; k < n + 20; k++) begin
      kk = k;
      a = m_acc + kk * m_ftw_act + m_poff_act;
      exp_q.push_back(phase_of(a));
    end
    pops = 0; first_pop = 1'b1; exp_period = int'(m_div) + 1;
    limit = (int'(m_div) + 1) * (n + 4) + 40;
    @(posedge clk); #2; mon_en = 1'b1;
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < limit && pops < n; i++) @(posedge clk);
    chk("run_reached_n", {31'h0, pops >= n}, 1);
    wr(A_CTRL, 32'h0);
    repeat (12) @(posedge clk);
    #2; mon_en = 1'b0;
    kk = pops;
    m_acc = m_acc + kk * m_ftw_act;
    rd_chk("acc_after_run", A_ACC, m_acc);
  endtask

  initial begin
    logic [31:0] rd, a1, a2, d;
    logic got;
    logic [3:0] s;
    logic [11:0] s0;

    repeat (3) @(posedge clk);
    #2; rst = 0;
    #1;
    chk("rst_ack", {31'h0, ack}, 0);
    chk("rst_valid", {31'h0, valid}, 0);
    chk("rst_phase", {20'h0, phase}, 0);
    chk("rst_dat", rdat_o, 0);
    for (int i = 0; i < 6; i++) rd_chk("rst_reg", BASE + 32'(i * 4), 0);
    rd_chk("unmapped", BASE + 32'h20, 0);
    xfer(BASE + 32'h100, 1'b0, 0, 4'hF, rd, got);
    chk("base_miss_noack", {31'h0, got}, 0);

    // ramp at full rate
    m_ftw_sh = 32'h1000_0000;
    wr(A_FTW, m_ftw_sh);
    wr(A_CTRL, 32'h4); apply_model();
    m_div = 0; wr(A_DIV, 0);
    run(17);

    // divided rate
    m_div = 3; wr(A_DIV, 32'h3);
    rd_chk("div_rb", A_DIV, 32'h3);
    run(8);

    // overrun with ready held low
    m_div = 0; wr(A_DIV, 0);
    s0 = phase_of(m_acc + m_poff_act);
    @(posedge clk); #2; ready = 0;
    wr(A_CTRL, 32'h1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ovr_valid", {31'h0, valid}, 1);
    chk("ovr_phase_held", {20'h0, phase}, {20'h0, s0});
    rd_chk("ovr_status", A_STAT, 32'h3);
    xfer(A_ACC, 1'b0, 0, 4'hF, a1, got);
    xfer(A_ACC, 1'b0, 0, 4'hF, a2, got);
    chk("ovr_acc_adv", a2 - a1, 2 * m_ftw_act);
    wr(A_CTRL, 32'h0);
    @(posedge clk); #2; ready = 1;
    @(negedge clk);
    chk("ovr_drain_valid", {31'h0, valid}, 1);
    chk("ovr_drain_phase", {20'h0, phase}, {20'h0, s0});
    @(negedge clk);
    chk("ovr_drained", {31'h0, valid}, 0);
    wr(A_STAT, 32'h1);
    rd_chk("ovr_w1c", A_STAT, 32'h0);
    wr(A_CTRL, 32'h2); m_acc = 0;
    rd_chk("clr_acc", A_ACC, 0);

    // shadow without apply, then apply, then offset
    m_ftw_sh = 32'h2000_0000; wr(A_FTW, m_ftw_sh);
    rd_chk("ftw_sh_rb", A_FTW, m_ftw_sh);
    run(6);
    wr(A_CTRL, 32'h4); apply_model();
    run(6);
    m_poff_sh = 32'h8000_0000; wr(A_POFF, m_poff_sh);
    wr(A_CTRL, 32'h4); apply_model();
    run(6);

    // clear while running
    wr(A_CTRL, 32'h1);
    repeat (5) @(posedge clk);
    wr(A_CTRL, 32'h3);
    @(negedge clk);
    chk("clr_valid_low", {31'h0, valid}, 0);
    @(negedge clk);
    chk("clr_first_valid", {31'h0, valid}, 1);
    chk("clr_first_phase", {20'h0, phase}, 32'h800);
    @(negedge clk);
    chk("clr_second_phase", {20'h0, phase}, 32'hA00);
    wr(A_CTRL, 32'h0);
    repeat (4) @(posedge clk);

    // CLR and APPLY in one write
    m_ftw_sh = $urandom; wr(A_FTW, m_ftw_sh);
    wr(A_CTRL, 32'h6); apply_model(); m_acc = 0;
    rd_chk("clr_apply_acc", A_ACC, 0);
    run(5);

    // byte lanes
    d = 32'hAABB_CCDD;
    wr(A_FTW, d, 4'b0001); m_ftw_sh = bmerge(m_ftw_sh, d, 4'b0001);
    rd_chk("sel_byte0", A_FTW, m_ftw_sh);
    for (int i = 0; i < 4; i++) begin
      d = $urandom; s = 4'($urandom_range(0, 15));
      wr(A_POFF, d, s); m_poff_sh = bmerge(m_poff_sh, d, s);
      rd_chk("sel_poff", A_POFF, m_poff_sh);
    end

    // randomized programming and runs
    for (int r = 0; r < 5; r++) begin
      m_ftw_sh = $urandom; m_poff_sh = $urandom; m_div = 16'($urandom_range(0, 3));
      wr(A_FTW, m_ftw_sh); wr(A_POFF, m_poff_sh); wr(A_DIV, {16'h0, m_div});
      rd_chk("rnd_ftw", A_FTW, m_ftw_sh);
      rd_chk("rnd_div", A_DIV, {16'h0, m_div});
      wr(A_CTRL, 32'h4); apply_model();
      run($urandom_range(4, 12));
    end

    // reset during a write
    @(posedge clk); #2;
    stb = 1; cyc = 1; we = 1; adr = A_FTW; wdat = 32'hFFFF_FFFF; sel = 4'hF; rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_noack", {31'h0, ack}, 0);
    stb = 0; cyc = 0; we = 0; rst = 0;
    rd_chk("rst_mid_ftw", A_FTW, 0);
    rd_chk("rst_mid_acc", A_ACC, 0);
    chk("rst_mid_valid", {31'h0, valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
